ext_tid_rsp_tracker: RTL and testbench

- Response-side counterpart of the external TID allocator in the mchan ext unit.
- Records per-TID metadata and the expected beat count when a transaction issues.
- Consumes TID-tagged response beats and emits one completion per transaction carrying its metadata.
- Returns the TID to the allocator with a one-cycle release pulse and tracks the outstanding count.

---
 rtl/ext_tid_rsp_tracker.sv | 182 ++++++++++++++++++
 tb/tb_ext_tid_rsp_tracker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_tid_rsp_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ext_tid_rsp_tracker
// Description : Response-side tracker for external TIDs. Records metadata and
//               the expected beat count (beats-1) on issue, consumes
//               TID-tagged response beats, emits one completion per
//               transaction through a single-slot completion register, pulses
//               a release back to the TID allocator and counts busy entries.
// Ports       : clk_i/rst_i           clock, async active-high reset
//               issue_*_i             transaction issue (no backpressure)
//               rsp_valid_i/rsp_tid_i response beat, rsp_ready_o handshake
//               cpl_*                 completion valid/ready with tid + meta
//               release_tid_*_o       one-cycle TID release pulse + id
//               outstanding_o/idle_o  busy entry count, idle flag
//               err_o/err_tid_o       protocol error pulse + offending TID
// Options     : EXT_TID_TRACK_ERR_EN  enables the protocol error reporting;
//               when undefined err_o/err_tid_o are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_tid_rsp_tracker #(
    parameter int EXT_TID_WIDTH  = 4,
    parameter int META_WIDTH     = 8,
    parameter int BEAT_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    input  logic [EXT_TID_WIDTH-1:0]  issue_tid_i,
    input  logic [META_WIDTH-1:0]     issue_meta_i,
    input  logic [BEAT_CNT_WIDTH-1:0] issue_beats_i,
    input  logic                      rsp_valid_i,
    input  logic [EXT_TID_WIDTH-1:0]  rsp_tid_i,
    output logic                      rsp_ready_o,
    output logic                      cpl_valid_o,
    output logic [EXT_TID_WIDTH-1:0]  cpl_tid_o,
    output logic [META_WIDTH-1:0]     cpl_meta_o,
    input  logic                      cpl_ready_i,
    output logic                      release_tid_o,
    output logic [EXT_TID_WIDTH-1:0]  release_tid_id_o,
    output logic [EXT_TID_WIDTH:0]    outstanding_o,
    output logic                      idle_o,
    output logic                      err_o,
    output logic [EXT_TID_WIDTH-1:0]  err_tid_o
);

    localparam int NB_TID = 2**EXT_TID_WIDTH;

    // Per-TID table
    logic [NB_TID-1:0]         busy_q,  busy_d;
    logic [META_WIDTH-1:0]     meta_q  [NB_TID];
    logic [META_WIDTH-1:0]     meta_d  [NB_TID];
    logic [BEAT_CNT_WIDTH-1:0] beats_q [NB_TID];
    logic [BEAT_CNT_WIDTH-1:0] beats_d [NB_TID];

    logic [EXT_TID_WIDTH:0]    outstanding_q, outstanding_d;
    logic                      cpl_valid_q;
    logic [EXT_TID_WIDTH-1:0]  cpl_tid_q;
    logic [META_WIDTH-1:0]     cpl_meta_q;
    logic                      release_q;
    logic [EXT_TID_WIDTH-1:0]  release_id_q;

    logic w_rsp_acc;
    logic w_rsp_hit;
    logic w_rsp_last;

    // Single completion slot: a beat may be accepted whenever the slot is
    // empty or is being drained in this same cycle.
    assign rsp_ready_o = !cpl_valid_q || cpl_ready_i;
    assign w_rsp_acc   = rsp_valid_i && rsp_ready_o;
    // Beats to idle TIDs are silently dropped.
    assign w_rsp_hit   = w_rsp_acc && busy_q[rsp_tid_i];
    assign w_rsp_last  = w_rsp_hit && (beats_q[rsp_tid_i] == '0);

    always_comb begin
        busy_d  = busy_q;
        meta_d  = meta_q;
        beats_d = beats_q;
        if (w_rsp_hit) begin
            if (w_rsp_last) begin
                busy_d[rsp_tid_i] = 1'b0;
            end else begin
                beats_d[rsp_tid_i] = beats_q[rsp_tid_i] - BEAT_CNT_WIDTH'(1);
            end
        end
        // Issue is applied last so it wins over a beat to the same TID.
        if (issue_valid_i) begin
            busy_d[issue_tid_i]  = 1'b1;
            meta_d[issue_tid_i]  = issue_meta_i;
            beats_d[issue_tid_i] = issue_beats_i;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue_valid_i && !w_rsp_last) begin
            outstanding_d = outstanding_q + (EXT_TID_WIDTH+1)'(1);
        end else if (!issue_valid_i && w_rsp_last) begin
            outstanding_d = outstanding_q - (EXT_TID_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            cpl_valid_q   <= 1'b0;
            cpl_tid_q     <= '0;
            cpl_meta_q    <= '0;
            release_q     <= 1'b0;
            release_id_q  <= '0;
            for (int i = 0; i < NB_TID; i++) begin
                meta_q[i]  <= '0;
                beats_q[i] <= '0;
            end
        end else begin
            busy_q        <= busy_d;
            meta_q        <= meta_d;
            beats_q       <= beats_d;
            outstanding_q <= outstanding_d;
            release_q     <= w_rsp_last;
            if (w_rsp_last) begin
                // Reload even while draining: back-to-back with no bubble.
                cpl_valid_q  <= 1'b1;
                cpl_tid_q    <= rsp_tid_i;
                cpl_meta_q   <= meta_q[rsp_tid_i];
                release_id_q <= rsp_tid_i;
            end else if (cpl_ready_i) begin
                cpl_valid_q  <= 1'b0;
            end
        end
    end

    assign cpl_valid_o      = cpl_valid_q;
    assign cpl_tid_o        = cpl_tid_q;
    assign cpl_meta_o       = cpl_meta_q;
    assign release_tid_o    = release_q;
    assign release_tid_id_o = release_id_q;
    assign outstanding_o    = outstanding_q;
    assign idle_o           = (outstanding_q == '0);

`ifdef EXT_TID_TRACK_ERR_EN
    logic                     err_q, err_d;
    logic [EXT_TID_WIDTH-1:0] err_tid_q, err_tid_d;
    logic                     w_rsp_err;
    logic                     w_iss_err;

    assign w_rsp_err = w_rsp_acc && !busy_q[rsp_tid_i];
    assign w_iss_err = issue_valid_i &&
                       (busy_q[issue_tid_i] || (w_rsp_acc && (issue_tid_i == rsp_tid_i)));

    always_comb begin
        err_d     = 1'b0;
        err_tid_d = err_tid_q;
        // Response-side error reports its TID in preference to issue errors.
        if (w_rsp_err) begin
            err_d     = 1'b1;
            err_tid_d = rsp_tid_i;
        end else if (w_iss_err) begin
            err_d     = 1'b1;
            err_tid_d = issue_tid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            err_tid_q <= '0;
        end else begin
            err_q     <= err_d;
            err_tid_q <= err_tid_d;
        end
    end

    assign err_o     = err_q;
    assign err_tid_o = err_tid_q;
`else
    assign err_o     = 1'b0;
    assign err_tid_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_tid_rsp_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_tid_rsp_tracker
// Description : Self-checking bench for ext_tid_rsp_tracker: directed
//               scenarios plus randomized traffic against a transaction-level
//               reference model (remaining-beat counters per TID).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_tid_rsp_tracker;

    localparam int TW = 4;
    localparam int MW = 8;
    localparam int BW = 8;
    localparam int NB = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          issue_valid_i;
    logic [TW-1:0] issue_tid_i;
    logic [MW-1:0] issue_meta_i;
    logic [BW-1:0] issue_beats_i;
    logic          rsp_valid_i;
    logic [TW-1:0] rsp_tid_i;
    logic          rsp_ready_o;
    logic          cpl_valid_o;
    logic [TW-1:0] cpl_tid_o;
    logic [MW-1:0] cpl_meta_o;
    logic          cpl_ready_i;
    logic          release_tid_o;
    logic [TW-1:0] release_tid_id_o;
    logic [TW:0]   outstanding_o;
    logic          idle_o;
    logic          err_o;
    logic [TW-1:0] err_tid_o;

    ext_tid_rsp_tracker #(.EXT_TID_WIDTH(TW), .META_WIDTH(MW), .BEAT_CNT_WIDTH(BW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_tid_i(issue_tid_i),
        .issue_meta_i(issue_meta_i), .issue_beats_i(issue_beats_i),
        .rsp_valid_i(rsp_valid_i), .rsp_tid_i(rsp_tid_i), .rsp_ready_o(rsp_ready_o),
        .cpl_valid_o(cpl_valid_o), .cpl_tid_o(cpl_tid_o), .cpl_meta_o(cpl_meta_o),
        .cpl_ready_i(cpl_ready_i),
        .release_tid_o(release_tid_o), .release_tid_id_o(release_tid_id_o),
        .outstanding_o(outstanding_o), .idle_o(idle_o),
        .err_o(err_o), .err_tid_o(err_tid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef EXT_TID_TRACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy [NB];
    logic [7:0]  m_meta [NB];
    int          m_need [NB];   // beats still expected
    int          m_out;
    bit          m_cv;
    logic [3:0]  m_ct;
    logic [7:0]  m_cm;
    bit          m_rel;
    logic [3:0]  m_rid;
    bit          m_err;
    logic [3:0]  m_etid;

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_busy[i] = 0; m_meta[i] = '0; m_need[i] = 0;
        end
        m_out = 0; m_cv = 0; m_ct = '0; m_cm = '0;
        m_rel = 0; m_rid = '0; m_err = 0; m_etid = '0;
    endtask

    // Predict the effect of the upcoming clock edge from the current inputs.
    task automatic model_step();
        bit acc, hit, last;
        int rt, it;
        rt   = int'(rsp_tid_i);
        it   = int'(issue_tid_i);
        acc  = rsp_valid_i && (!m_cv || cpl_ready_i);
        hit  = acc && m_busy[rt];
        last = hit && (m_need[rt] == 1);
        m_err = 0;
        if (ERR_EN) begin
            if (acc && !m_busy[rt]) begin
                m_err = 1; m_etid = rsp_tid_i;
            end else if (issue_valid_i && (m_busy[it] || (acc && it == rt))) begin
                m_err = 1; m_etid = issue_tid_i;
            end
        end
        if (last) begin
            m_cv = 1; m_ct = rsp_tid_i; m_cm = m_meta[rt];
        end else if (cpl_ready_i) begin
            m_cv = 0;
        end
        m_rel = last;
        if (last) m_rid = rsp_tid_i;
        if (hit) begin
            m_need[rt] = m_need[rt] - 1;
            if (m_need[rt] == 0) m_busy[rt] = 0;
        end
        if (issue_valid_i) begin
            m_busy[it] = 1; m_meta[it] = issue_meta_i; m_need[it] = int'(issue_beats_i) + 1;
        end
        m_out = m_out + int'(issue_valid_i) - int'(last);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i = 0; issue_tid_i = '0; issue_meta_i = '0; issue_beats_i = '0;
        rsp_valid_i = 0; rsp_tid_i = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1; idle_inputs(); cpl_ready_i = 1;
        m_reset();
        @(posedge clk_i); #1;
        n_cmp++; if (cpl_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_cpl_valid: got %0b want 0", cpl_valid_o); end
        n_cmp++; if (release_tid_o !== 1'b0) begin n_fail++; $display("FAIL rst_release: got %0b want 0", release_tid_o); end
        n_cmp++; if (outstanding_o !== 5'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding_o); end
        n_cmp++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %0b want 1", idle_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", err_o); end
        n_cmp++; if ({cpl_tid_o, cpl_meta_o, release_tid_id_o, err_tid_o} !== '0) begin n_fail++; $display("FAIL rst_ids: got %h want 0", {cpl_tid_o, cpl_meta_o, release_tid_id_o, err_tid_o}); end
        rst_i = 0;
    endtask

    task automatic test_single();
        issue_valid_i = 1; issue_tid_i = 4'd3; issue_meta_i = 8'hA5; issue_beats_i = 8'd0;
        tick();
        issue_valid_i = 0;
        n_cmp++; if (outstanding_o !== 5'd1) begin n_fail++; $display("FAIL single_out1: got %0d want 1", outstanding_o); end
        rsp_valid_i = 1; rsp_tid_i = 4'd3; cpl_ready_i = 1;
        tick();
        rsp_valid_i = 0;
        n_cmp++; if ({cpl_valid_o, cpl_tid_o, cpl_meta_o} !== {1'b1, 4'd3, 8'hA5}) begin n_fail++; $display("FAIL single_cpl: got %0b/%0d/%h want 1/3/a5", cpl_valid_o, cpl_tid_o, cpl_meta_o); end
        n_cmp++; if ({release_tid_o, release_tid_id_o} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL single_release: got %0b/%0d want 1/3", release_tid_o, release_tid_id_o); end
        n_cmp++; if ({outstanding_o, idle_o} !== {5'd0, 1'b1}) begin n_fail++; $display("FAIL single_idle: got %0d/%0b want 0/1", outstanding_o, idle_o); end
        tick();
        n_cmp++; if ({release_tid_o, cpl_valid_o} !== 2'b00) begin n_fail++; $display("FAIL single_pulse_end: got rel=%0b cpl=%0b want 0/0", release_tid_o, cpl_valid_o); end
    endtask

    task automatic test_multibeat();
        issue_valid_i = 1; issue_tid_i = 4'd0; issue_meta_i = 8'h5C; issue_beats_i = 8'd3;
        tick();
        issue_valid_i = 0; rsp_valid_i = 1; rsp_tid_i = 4'd0; cpl_ready_i = 1;
        for (int b = 1; b <= 3; b++) begin
            tick();
            n_cmp++; if ({cpl_valid_o, release_tid_o} !== 2'b00) begin n_fail++; $display("FAIL multibeat_early_b%0d: got cpl=%0b rel=%0b want 0/0", b, cpl_valid_o, release_tid_o); end
        end
        tick();
        rsp_valid_i = 0;
        n_cmp++; if ({cpl_valid_o, cpl_tid_o, cpl_meta_o, release_tid_o} !== {1'b1, 4'd0, 8'h5C, 1'b1}) begin n_fail++; $display("FAIL multibeat_cpl: got %0b/%0d/%h rel=%0b want 1/0/5c rel=1", cpl_valid_o, cpl_tid_o, cpl_meta_o, release_tid_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue_valid_i = 1; issue_tid_i = 4'd1; issue_meta_i = 8'h11; issue_beats_i = 8'd0;
        tick();
        issue_tid_i = 4'd2; issue_meta_i = 8'h22;
        tick();
        issue_valid_i = 0; cpl_ready_i = 0; rsp_valid_i = 1; rsp_tid_i = 4'd1;
        #1;
        n_cmp++; if (rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_first: got %0b want 1", rsp_ready_o); end
        tick();
        rsp_tid_i = 4'd2;
        #1;
        n_cmp++; if (rsp_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %0b want 0", rsp_ready_o); end
        tick();
        tick();
        n_cmp++; if ({cpl_valid_o, cpl_tid_o, cpl_meta_o} !== {1'b1, 4'd1, 8'h11}) begin n_fail++; $display("FAIL b2b_hold: got %0b/%0d/%h want 1/1/11", cpl_valid_o, cpl_tid_o, cpl_meta_o); end
        n_cmp++; if (outstanding_o !== 5'd1) begin n_fail++; $display("FAIL b2b_out_hold: got %0d want 1", outstanding_o); end
        cpl_ready_i = 1;
        #1;
        n_cmp++; if (rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_drain: got %0b want 1", rsp_ready_o); end
        tick();
        rsp_valid_i = 0;
        n_cmp++; if ({cpl_valid_o, cpl_tid_o, cpl_meta_o, release_tid_o, release_tid_id_o} !== {1'b1, 4'd2, 8'h22, 1'b1, 4'd2}) begin n_fail++; $display("FAIL b2b_reload: got %0b/%0d/%h rel=%0b/%0d want 1/2/22 rel=1/2", cpl_valid_o, cpl_tid_o, cpl_meta_o, release_tid_o, release_tid_id_o); end
        tick();
        n_cmp++; if (cpl_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got %0b want 0", cpl_valid_o); end
    endtask

    task automatic test_full();
        cpl_ready_i = 1;
        for (int i = 0; i < NB; i++) begin
            issue_valid_i = 1; issue_tid_i = TW'(i); issue_meta_i = MW'(i); issue_beats_i = 8'd0;
            tick();
        end
        issue_valid_i = 0;
        n_cmp++; if ({outstanding_o, idle_o} !== {5'd16, 1'b0}) begin n_fail++; $display("FAIL full_out16: got %0d/%0b want 16/0", outstanding_o, idle_o); end
        rsp_valid_i = 1; rsp_tid_i = 4'd5;
        tick();
        n_cmp++; if (outstanding_o !== 5'd15) begin n_fail++; $display("FAIL full_out15: got %0d want 15", outstanding_o); end
        issue_valid_i = 1; issue_tid_i = 4'd5; issue_meta_i = 8'h55; rsp_tid_i = 4'd7;
        tick();
        n_cmp++; if ({outstanding_o, cpl_tid_o, release_tid_o, release_tid_id_o} !== {5'd15, 4'd7, 1'b1, 4'd7}) begin n_fail++; $display("FAIL full_simul: got out=%0d cpl=%0d rel=%0b/%0d want 15/7/1/7", outstanding_o, cpl_tid_o, release_tid_o, release_tid_id_o); end
        issue_tid_i = 4'd7; issue_meta_i = 8'h77; rsp_valid_i = 0;
        tick();
        issue_valid_i = 0;
        n_cmp++; if (outstanding_o !== 5'd16) begin n_fail++; $display("FAIL full_reissue: got %0d want 16", outstanding_o); end
        rsp_valid_i = 1;
        for (int i = 0; i < NB; i++) begin
            logic [7:0] exp_meta;
            exp_meta = (i == 5) ? 8'h55 : (i == 7) ? 8'h77 : MW'(i);
            rsp_tid_i = TW'(i);
            tick();
            n_cmp++; if ({cpl_valid_o, cpl_tid_o, cpl_meta_o} !== {1'b1, TW'(i), exp_meta}) begin n_fail++; $display("FAIL full_drain_%0d: got %0b/%0d/%h want 1/%0d/%h", i, cpl_valid_o, cpl_tid_o, cpl_meta_o, i, exp_meta); end
        end
        rsp_valid_i = 0;
        tick();
        n_cmp++; if ({outstanding_o, idle_o} !== {5'd0, 1'b1}) begin n_fail++; $display("FAIL full_empty: got %0d/%0b want 0/1", outstanding_o, idle_o); end
    endtask

    task automatic test_drop();
        cpl_ready_i = 1; rsp_valid_i = 1; rsp_tid_i = 4'd9;
        tick();
        rsp_valid_i = 0;
        n_cmp++; if ({cpl_valid_o, release_tid_o, outstanding_o} !== {1'b0, 1'b0, 5'd0}) begin n_fail++; $display("FAIL drop_effect: got cpl=%0b rel=%0b out=%0d want 0/0/0", cpl_valid_o, release_tid_o, outstanding_o); end
        n_cmp++; if (err_o !== ERR_EN) begin n_fail++; $display("FAIL drop_err: got %0b want %0b", err_o, ERR_EN); end
        if (ERR_EN) begin
            n_cmp++; if (err_tid_o !== 4'd9) begin n_fail++; $display("FAIL drop_err_tid: got %0d want 9", err_tid_o); end
        end else begin
            n_cmp++; if (err_tid_o !== 4'd0) begin n_fail++; $display("FAIL drop_err_tid: got %0d want 0", err_tid_o); end
        end
        tick();
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL drop_err_pulse: got %0b want 0", err_o); end
    endtask

    task automatic test_reset_mid();
        cpl_ready_i = 0;
        for (int i = 10; i < 14; i++) begin
            issue_valid_i = 1; issue_tid_i = TW'(i); issue_meta_i = 8'hE0 + MW'(i); issue_beats_i = 8'd0;
            tick();
        end
        issue_valid_i = 0; rsp_valid_i = 1; rsp_tid_i = 4'd10;
        tick();
        rsp_valid_i = 0;
        n_cmp++; if ({cpl_valid_o, outstanding_o} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL rstmid_pre: got cpl=%0b out=%0d want 1/3", cpl_valid_o, outstanding_o); end
        rst_i = 1;
        #1;
        n_cmp++; if ({cpl_valid_o, release_tid_o, outstanding_o, idle_o, cpl_tid_o, cpl_meta_o} !== {1'b1 ^ 1'b1, 1'b0, 5'd0, 1'b1, 4'd0, 8'd0}) begin n_fail++; $display("FAIL rstmid_async: got cpl=%0b rel=%0b out=%0d idle=%0b tid=%0d meta=%h want 0/0/0/1/0/00", cpl_valid_o, release_tid_o, outstanding_o, idle_o, cpl_tid_o, cpl_meta_o); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (release_tid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_release: got %0b want 0", release_tid_o); end
        end
        rst_i = 0; m_reset(); cpl_ready_i = 1;
        issue_valid_i = 1; issue_tid_i = 4'd11; issue_meta_i = 8'hC3; issue_beats_i = 8'd0;
        tick();
        issue_valid_i = 0; rsp_valid_i = 1; rsp_tid_i = 4'd11;
        tick();
        rsp_valid_i = 0;
        n_cmp++; if ({cpl_valid_o, cpl_tid_o, cpl_meta_o, outstanding_o} !== {1'b1, 4'd11, 8'hC3, 5'd0}) begin n_fail++; $display("FAIL rstmid_after: got %0b/%0d/%h out=%0d want 1/11/c3/0", cpl_valid_o, cpl_tid_o, cpl_meta_o, outstanding_o); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            int freel[$];
            int busyl[$];
            freel = {}; busyl = {};
            for (int i = 0; i < NB; i++) begin
                if (m_busy[i]) busyl.push_back(i); else freel.push_back(i);
            end
            idle_inputs();
            if (freel.size() > 0 && $urandom_range(0, 2) != 0) begin
                issue_valid_i = 1;
                issue_tid_i   = TW'(freel[$urandom_range(0, freel.size() - 1)]);
                issue_meta_i  = MW'($urandom);
                issue_beats_i = BW'($urandom_range(0, 3));
            end
            if (busyl.size() > 0 && $urandom_range(0, 3) != 0) begin
                rsp_valid_i = 1;
                rsp_tid_i   = TW'(busyl[$urandom_range(0, busyl.size() - 1)]);
            end else if ($urandom_range(0, 7) == 0) begin
                // stray beat to an idle TID, never the one being issued
                int t;
                t = freel.size() > 0 ? freel[$urandom_range(0, freel.size() - 1)] : 0;
                if (freel.size() > 0 && !(issue_valid_i && TW'(t) == issue_tid_i)) begin
                    rsp_valid_i = 1; rsp_tid_i = TW'(t);
                end
            end
            cpl_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++; if (rsp_ready_o !== (!m_cv || cpl_ready_i)) begin n_fail++; $display("FAIL rnd_rsp_ready c%0d: got %0b want %0b", c, rsp_ready_o, (!m_cv || cpl_ready_i)); end
            tick();
            n_cmp++; if (cpl_valid_o !== m_cv) begin n_fail++; $display("FAIL rnd_cpl_valid c%0d: got %0b want %0b", c, cpl_valid_o, m_cv); end
            if (m_cv) begin
                n_cmp++; if ({cpl_tid_o, cpl_meta_o} !== {m_ct, m_cm}) begin n_fail++; $display("FAIL rnd_cpl_data c%0d: got %0d/%h want %0d/%h", c, cpl_tid_o, cpl_meta_o, m_ct, m_cm); end
            end
            n_cmp++; if (release_tid_o !== m_rel) begin n_fail++; $display("FAIL rnd_release c%0d: got %0b want %0b", c, release_tid_o, m_rel); end
            if (m_rel) begin
                n_cmp++; if (release_tid_id_o !== m_rid) begin n_fail++; $display("FAIL rnd_release_id c%0d: got %0d want %0d", c, release_tid_id_o, m_rid); end
            end
            n_cmp++; if ({outstanding_o, idle_o} !== {5'(m_out), m_out == 0}) begin n_fail++; $display("FAIL rnd_outstanding c%0d: got %0d/%0b want %0d/%0b", c, outstanding_o, idle_o, m_out, m_out == 0); end
            n_cmp++; if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %0b want %0b", c, err_o, m_err); end
            if (m_err) begin
                n_cmp++; if (err_tid_o !== m_etid) begin n_fail++; $display("FAIL rnd_err_tid c%0d: got %0d want %0d", c, err_tid_o, m_etid); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multibeat();
        test_back_to_back();
        test_full();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
